// File: rtl/mpmp_fifo_pkg.sv
// mpmp_fifo_pkg: width and wrap arithmetic helpers
// shared by the multi-push/multi-pop FIFO files.
package mpmp_fifo_pkg;

    function automatic int cw(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // k never exceeds d, so one conditional subtract is a full modulo
    function automatic int wrap_add(input int p, input int k, input int d);
        int s;
        s = p + k;
        return (s >= d) ? s - d : s;
    endfunction

endpackage

// File: rtl/mpmp_fifo_flush_if.sv
// mpmp_fifo_flush_if: push/pop lane bundle of the FIFO.
// master = producer/consumer side, slave = FIFO side.
interface mpmp_fifo_flush_if #(
    parameter int W  = 8,
    parameter int D  = 6,
    parameter int NI = 4,
    parameter int NO = 3
);
    import mpmp_fifo_pkg::*;

    localparam int IW = cw(NI);
    localparam int OW = cw(NO);
    localparam int CW = cw(D);

    logic                   flush;
    logic [IW-1:0]          push;
    logic [NI-1:0][W-1:0]   push_data;
    logic [OW-1:0]          pop;
    logic [NO-1:0][W-1:0]   pop_data;
    logic [IW-1:0]          can_push;
    logic [OW-1:0]          can_pop;
    logic [CW-1:0]          count;
    logic                   almost_full;
    logic                   err_ovf;
    logic                   err_udf;

    modport master (
        output flush, push, push_data, pop,
        input  pop_data, can_push, can_pop, count,
        input  almost_full, err_ovf, err_udf
    );

    modport slave (
        input  flush, push, push_data, pop,
        output pop_data, can_push, can_pop, count,
        output almost_full, err_ovf, err_udf
    );

endinterface

// File: rtl/mpmp_fifo_ptr.sv
// mpmp_fifo_ptr: pointer register advancing by k words,
// wrapping modulo a depth D that need not be a power of two.
module mpmp_fifo_ptr #(
    parameter int D  = 6,
    parameter int KW = 3,
    localparam int PW = (D > 1) ? $clog2(D) : 1
) (
    input  logic          clk,
    input  logic          arstn,
    input  logic          clr,
    input  logic [KW-1:0] k,
    output logic [PW-1:0] ptr
);
    import mpmp_fifo_pkg::*;

    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = PW'(wrap_add(int'(ptr), int'(k), D));
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_d;
        end
    end

endmodule

// File: rtl/mpmp_fifo_flush.sv
// mpmp_fifo_flush: show-ahead multi-push/multi-pop FIFO with flush.
// Define MPMP_FIFO_ERR_EN to build sticky err_ovf/err_udf flags.
module mpmp_fifo_flush #(
    parameter int W  = 8,
    parameter int D  = 6,
    parameter int NI = 4,
    parameter int NO = 3,
    parameter int AF = D - 1
) (
    input  logic               clk,
    input  logic               arstn,
    mpmp_fifo_flush_if.slave   f
);
    import mpmp_fifo_pkg::*;

    localparam int IW = cw(NI);
    localparam int OW = cw(NO);
    localparam int CW = cw(D);
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem [D];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [IW-1:0] can_push;
    logic [IW-1:0] push_acc;
    logic [OW-1:0] can_pop;
    logic [OW-1:0] pop_acc;

    // space/data offered depends only on registered count
    always_comb begin
        can_push = IW'(min_i(NI, D - int'(count_q)));
        can_pop  = OW'(min_i(NO, int'(count_q)));
        push_acc = IW'(min_i(int'(f.push), int'(can_push)));
        pop_acc  = OW'(min_i(int'(f.pop), int'(can_pop)));
    end

    mpmp_fifo_ptr #(.D(D), .KW(IW)) u_wr_ptr (
        .clk   (clk),
        .arstn (arstn),
        .clr   (f.flush),
        .k     (push_acc),
        .ptr   (wr_ptr)
    );

    mpmp_fifo_ptr #(.D(D), .KW(OW)) u_rd_ptr (
        .clk   (clk),
        .arstn (arstn),
        .clr   (f.flush),
        .k     (pop_acc),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!f.flush) begin
            for (int i = 0; i < NI; i++) begin
                if (i < int'(push_acc)) begin
                    mem[PW'(wrap_add(int'(wr_ptr), i, D))] <= f.push_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count_q <= '0;
        end else if (f.flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(push_acc) - CW'(pop_acc);
        end
    end

    always_comb begin
        f.pop_data = '0;
        for (int i = 0; i < NO; i++) begin
            if (i < int'(can_pop)) begin
                f.pop_data[i] = mem[PW'(wrap_add(int'(rd_ptr), i, D))];
            end
        end
    end

    assign f.can_push    = can_push;
    assign f.can_pop     = can_pop;
    assign f.count       = count_q;
    assign f.almost_full = (count_q >= CW'(AF));

`ifdef MPMP_FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (f.flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (f.push > can_push);
            udf_q <= udf_q | (f.pop > can_pop);
        end
    end

    assign f.err_ovf = ovf_q;
    assign f.err_udf = udf_q;
`else
    assign f.err_ovf = 1'b0;
    assign f.err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_mpmp_fifo_flush.sv
// tb_mpmp_fifo_flush: directed vectors against a queue model
// of the multi-push/multi-pop FIFO, plus literal spot checks.
module tb_mpmp_fifo_flush;

    localparam int W  = 8;
    localparam int D  = 6;
    localparam int NI = 4;
    localparam int NO = 3;
    localparam int AF = 5;
`ifdef MPMP_FIFO_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic arstn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    byte unsigned q[$];
    bit           m_ovf;
    bit           m_udf;
    int           m_n, m_cpu, m_cpo, m_pa, m_po;
    int           e_n;
    logic [23:0]  e_pd;

    mpmp_fifo_flush_if #(.W(W), .D(D), .NI(NI), .NO(NO)) f ();

    mpmp_fifo_flush #(.W(W), .D(D), .NI(NI), .NO(NO), .AF(AF)) dut (
        .clk   (clk),
        .arstn (arstn),
        .f     (f)
    );

    always #5 clk = ~clk;

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: a queue of words plus two sticky bits
    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (f.flush) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_n   = q.size();
            m_cpu = mn(NI, D - m_n);
            m_cpo = mn(NO, m_n);
            m_pa  = mn(int'(f.push), m_cpu);
            m_po  = mn(int'(f.pop), m_cpo);
            if (ERR && int'(f.push) > m_cpu) m_ovf = 1'b1;
            if (ERR && int'(f.pop) > m_cpo) m_udf = 1'b1;
            repeat (m_po) void'(q.pop_front());
            for (int i = 0; i < m_pa; i++) q.push_back(f.push_data[i]);
        end
    end

    always @(negedge clk) begin
        if (arstn && chk_en) begin
            e_n  = q.size();
            e_pd = '0;
            for (int i = 0; i < mn(NO, e_n); i++) e_pd[i*W +: W] = q[i];
            check("m_count", 64'(f.count), 64'(e_n));
            check("m_can_push", 64'(f.can_push), 64'(mn(NI, D - e_n)));
            check("m_can_pop", 64'(f.can_pop), 64'(mn(NO, e_n)));
            check("m_almost_full", 64'(f.almost_full), 64'(e_n >= AF));
            check("m_pop_data", 64'(f.pop_data), 64'(e_pd));
            check("m_err_ovf", 64'(f.err_ovf), 64'(m_ovf));
            check("m_err_udf", 64'(f.err_udf), 64'(m_udf));
        end
    end

    task automatic step(input bit fl, input int pu, input logic [31:0] pd,
                        input int po);
        f.flush     = fl;
        f.push      = 3'(pu);
        f.push_data = pd;
        f.pop       = 2'(po);
        @(negedge clk);
        f.flush     = 1'b0;
        f.push      = '0;
        f.push_data = '0;
        f.pop       = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_can_push"}, 64'(f.can_push), 64'd4);
        check({tag, "_can_pop"}, 64'(f.can_pop), 64'd0);
        check({tag, "_count"}, 64'(f.count), 64'd0);
        check({tag, "_pop_data"}, 64'(f.pop_data), 64'd0);
        check({tag, "_af"}, 64'(f.almost_full), 64'd0);
        check({tag, "_ovf"}, 64'(f.err_ovf), 64'd0);
        check({tag, "_udf"}, 64'(f.err_udf), 64'd0);
    endtask

    int          tv_push [10] = '{4, 4, 1, 0, 2, 3, 4, 0, 1, 2};
    int          tv_pop  [10] = '{0, 1, 3, 3, 2, 0, 3, 3, 3, 1};
    logic [31:0] tv_data [10] = '{32'h44434241, 32'h48474645, 32'h0000004C,
                                  32'h0, 32'h00005251, 32'h00565554,
                                  32'h5C5B5A59, 32'h0, 32'h00000060,
                                  32'h00006463};

    initial begin
        f.flush     = 1'b0;
        f.push      = '0;
        f.push_data = '0;
        f.pop       = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        arstn  = 1'b1;
        chk_en = 1'b1;

        step(0, 3, 32'h00030201, 0);
        check("basic_count", 64'(f.count), 64'd3);
        check("basic_can_pop", 64'(f.can_pop), 64'd3);
        check("basic_can_push", 64'(f.can_push), 64'd3);
        check("basic_pop_data", 64'(f.pop_data), 64'h030201);
        step(0, 0, 0, 3);

        step(1, 0, 0, 0);
        step(0, 4, 32'h0D0C0B0A, 0);
        step(0, 2, 32'h00000F0E, 3);
        check("wrap_count", 64'(f.count), 64'd3);
        check("wrap_pop_data", 64'(f.pop_data), 64'h0F0E0D);

        step(1, 0, 0, 0);
        step(0, 4, 32'h17161514, 0);
        step(0, 2, 32'h00001918, 0);
        check("full_count", 64'(f.count), 64'd6);
        check("full_can_push", 64'(f.can_push), 64'd0);
        check("full_af", 64'(f.almost_full), 64'd1);
        step(0, 1, 32'h0000001A, 0);
        check("ovf_count", 64'(f.count), 64'd6);
        check("ovf_flag", 64'(f.err_ovf), 64'(ERR));
        check("ovf_pop_data", 64'(f.pop_data), 64'h161514);
        step(0, 0, 0, 1);
        check("pop1_count", 64'(f.count), 64'd5);
        check("pop1_pop_data", 64'(f.pop_data), 64'h171615);

        step(1, 2, 32'h00002221, 0);
        check("flush_count", 64'(f.count), 64'd0);
        check("flush_ovf", 64'(f.err_ovf), 64'd0);
        check("flush_can_pop", 64'(f.can_pop), 64'd0);

        step(0, 1, 32'h0000001E, 0);
        step(0, 0, 0, 2);
        check("udf_count", 64'(f.count), 64'd0);
        check("udf_flag", 64'(f.err_udf), 64'(ERR));
        check("udf_pop_data", 64'(f.pop_data), 64'd0);

        for (int i = 0; i < 10; i++) step(0, tv_push[i], tv_data[i], tv_pop[i]);

        step(1, 0, 0, 0);
        step(0, 3, 32'h002A2928, 0);
        check("mid_pop_data", 64'(f.pop_data), 64'h2A2928);
        #2 arstn = 1'b0;
        #1 check_reset_vals("async");
        @(negedge clk);
        arstn = 1'b1;
        step(0, 2, 32'h00003433, 0);
        check("post_rst_count", 64'(f.count), 64'd2);
        check("post_rst_pop_data", 64'(f.pop_data), 64'h003433);
        step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
